instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports in the order below.
REQ-002 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, instruction fields valid.
REQ-005 SHALL have port in_ready, output, 1, encoder can accept an instruction.
REQ-006 SHALL have ports icode and ifun, input, 4 each, instruction code and function.
REQ-007 SHALL have ports rA and rB, input, 4 each, register specifiers.
REQ-008 SHALL have port valC, input, 64, constant word.
REQ-009 SHALL have port out_valid, output, 1, out_byte valid.
REQ-010 SHALL have port out_ready, input, 1, downstream byte sink ready.
REQ-011 SHALL have port out_byte, output, 8, current instruction byte.
REQ-012 SHALL have port out_last, output, 1, out_byte is the final byte of the instruction.
REQ-013 SHALL have port instr_err, output, 1, one-cycle pulse for an invalid icode.
REQ-014 SHALL have ports pc_load (input, 1), pc_init (input, 64) and out_pc (output, 64), present only when ENC_PC_EN is defined.

Function
REQ-015 SHALL derive instruction length from the captured icode:
  - 0, 1, 9: 1 byte.
  - 2, 6, A, B: 2 bytes.
  - 7, 8: 9 bytes.
  - 3, 4, 5: 10 bytes.
  - C-F: invalid.
REQ-016 SHALL emit byte order:
  - {icode,ifun}.
  - {rA,rB} if regids are needed (icode 2-6, A, B).
  - valC little-endian, valC[7:0] first through valC[63:56], if a constant is needed (icode 3, 4, 5, 7, 8).
REQ-017 SHALL implement FSM states IDLE, HDR, REG, CONST; CONST uses a 3-bit byte index 0..7.
REQ-018 SHALL assert in_ready only in IDLE; an instruction is accepted on in_valid&&in_ready, registering all fields.
REQ-019 SHALL transition on acceptance as follows:
  - valid icode: IDLE->HDR, with out_valid=1 and the first byte on the next cycle.
  - invalid icode: pulse instr_err for exactly one cycle, emit no bytes, stay in IDLE.
REQ-020 SHALL advance one byte per out_valid&&out_ready; out_byte, out_valid and out_last SHALL hold stable while out_ready=0.
REQ-021 SHALL make these transitions on a byte handshake:
  - HDR->REG if regids needed, else HDR->CONST if a constant is needed, else HDR->IDLE.
  - REG->CONST if a constant is needed, else REG->IDLE.
  - CONST index 7->IDLE.
REQ-022 SHALL assert out_last exactly with the final byte; in_ready SHALL return the cycle after the final handshake (no same-cycle accept).
REQ-023 SHALL drive out_byte=0 and out_last=0 whenever out_valid=0.
REQ-024 SHALL drive all outputs from registers, except in_ready, which is decoded from state.

Reset
REQ-025 SHALL, on reset, force state IDLE, out_valid=0, out_byte=0, out_last=0, instr_err=0 and out_pc=0.
REQ-026 SHALL abandon any in-progress instruction on reset mid-operation, emitting no further bytes; in_ready=1 the cycle after reset deasserts.

Configuration
REQ-027 SHALL use macro ENC_PC_EN to compile in or out the byte address counter:
  - Defined: out_pc gives the address of the current out_byte and increments by 1 per byte handshake, wrapping from 2^64-1 to 0.
  - Defined: pc_load loads pc_init, is honoured only in IDLE and takes priority over acceptance in the same cycle.
  - Undefined: the ports and counter are absent; all other behaviour is identical.

Verification
REQ-028 SHALL pass: irmovq with icode=3, ifun=0, rA=F, rB=2, valC=0x0123456789ABCDEF, out_ready=1 -> bytes 30,F2,EF,CD,AB,89,67,45,23,01 on 10 consecutive cycles, out_last on 01.
REQ-029 SHALL pass: call with icode=8, valC=0x100 -> 9 bytes 80,00,01,00,00,00,00,00,00; no register byte.
REQ-030 SHALL pass: addq (icode 6, ifun 0, rA=1, rB=2) with out_ready toggling 0/1 each cycle -> bytes 60,12, each held while out_ready=0, out_last on 12.
REQ-031 SHALL pass: icode=D -> instr_err high one cycle, out_valid stays 0, in_ready=1 next cycle.
REQ-032 SHALL pass: reset asserted after the 4th byte of rmmovq -> out_valid=0 next cycle; a following nop emits the single byte 10.
REQ-033 SHALL pass (ENC_PC_EN): pc_load with pc_init=0xFFFFFFFFFFFFFFFF, then rrmovq -> out_pc FFFF..FF then 0.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: serialises one instruction (icode/ifun, register specifiers,
// 64-bit constant) into a stream of bytes over a valid/ready byte interface.
// Optional feature: define ENC_PC_EN to add a byte address counter
// (pc_load / pc_init / out_pc).
module instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valC,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_last,
    output logic        instr_err
`ifdef ENC_PC_EN
    ,
    input  logic        pc_load,
    input  logic [63:0] pc_init,
    output logic [63:0] out_pc
`endif
);

    typedef enum logic [1:0] {IDLE, HDR, REG, CONST} state_t;

    state_t      state, state_n;
    logic [2:0]  idx, idx_n;
    logic [3:0]  icode_q, ifun_q, ra_q, rb_q;
    logic [63:0] valc_q;
    logic        fire, accept, load_now;
    logic [3:0]  cur_icode, cur_ifun;
    logic        valid_n, last_n, err_n;
    logic [7:0]  byte_n;

    function automatic logic icode_ok(input logic [3:0] c);
        return (c <= 4'hB);
    endfunction

    function automatic logic need_reg(input logic [3:0] c);
        case (c)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    function automatic logic need_const(input logic [3:0] c);
        case (c)
            4'h3, 4'h4, 4'h5, 4'h7, 4'h8: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    assign in_ready = (state == IDLE);
    assign fire     = out_valid && out_ready;

`ifdef ENC_PC_EN
    assign load_now = pc_load && (state == IDLE);
`else
    assign load_now = 1'b0;
`endif

    // A pending pc load wins over instruction acceptance in the same cycle
    assign accept = in_valid && in_ready && !load_now;

    // State register and constant byte index
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= 3'd0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    // Next-state decode: advance only on a byte handshake
    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            IDLE: begin
                if (accept && icode_ok(icode)) state_n = HDR;
            end
            HDR: begin
                if (fire) begin
                    if (need_reg(icode_q)) begin
                        state_n = REG;
                    end else if (need_const(icode_q)) begin
                        state_n = CONST;
                        idx_n   = 3'd0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            REG: begin
                if (fire) begin
                    if (need_const(icode_q)) begin
                        state_n = CONST;
                        idx_n   = 3'd0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            CONST: begin
                if (fire) begin
                    if (idx == 3'd7) state_n = IDLE;
                    else             idx_n   = idx + 3'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output decode for the byte that will be presented next cycle; the header
    // comes straight from the inputs on the accepting cycle
    always_comb begin
        cur_icode = (state == IDLE) ? icode : icode_q;
        cur_ifun  = (state == IDLE) ? ifun  : ifun_q;
        valid_n   = (state_n != IDLE);
        byte_n    = 8'h00;
        last_n    = 1'b0;
        err_n     = accept && !icode_ok(icode);
        case (state_n)
            HDR: begin
                byte_n = {cur_icode, cur_ifun};
                last_n = !need_reg(cur_icode) && !need_const(cur_icode);
            end
            REG: begin
                byte_n = {ra_q, rb_q};
                last_n = !need_const(icode_q);
            end
            CONST: begin
                byte_n = valc_q[{idx_n, 3'b000} +: 8];
                last_n = (idx_n == 3'd7);
            end
            default: begin
                byte_n = 8'h00;
                last_n = 1'b0;
            end
        endcase
    end

    // Capture instruction fields on acceptance
    always_ff @(posedge clk) begin
        if (accept) begin
            icode_q <= icode;
            ifun_q  <= ifun;
            ra_q    <= rA;
            rb_q    <= rB;
            valc_q  <= valC;
        end
    end

    // Registered byte-stream outputs and error pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_byte  <= 8'h00;
            out_last  <= 1'b0;
            instr_err <= 1'b0;
        end else begin
            out_valid <= valid_n;
            out_byte  <= byte_n;
            out_last  <= last_n;
            instr_err <= err_n;
        end
    end

`ifdef ENC_PC_EN
    // Byte address counter: load in IDLE, bump on every byte handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            out_pc <= 64'd0;
        end else if (load_now) begin
            out_pc <= pc_init;
        end else if (fire) begin
            out_pc <= out_pc + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed test of instr_encoder with hand-computed byte
// sequences. Address counter checks are included when ENC_PC_EN is defined.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        instr_err;
`ifdef ENC_PC_EN
    logic        pc_load;
    logic [63:0] pc_init;
    logic [63:0] out_pc;
`endif

    int errorCount = 0;
    int checkCount = 0;

    instr_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .icode     (icode),
        .ifun      (ifun),
        .rA        (rA),
        .rB        (rB),
        .valC      (valC),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last),
        .instr_err (instr_err)
`ifdef ENC_PC_EN
        ,
        .pc_load   (pc_load),
        .pc_init   (pc_init),
        .out_pc    (out_pc)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Single comparison point; every check goes through here
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Step one clock and settle just after the rising edge
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single cycle; the first byte is visible afterwards
    task automatic applyStimulus(input logic [3:0] c, input logic [3:0] f,
                                 input logic [3:0] a, input logic [3:0] b,
                                 input logic [63:0] k);
        checkOutput("in_ready_before_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        icode    = c;
        ifun     = f;
        rA       = a;
        rB       = b;
        valC     = k;
        stepCycle();
        in_valid = 1'b0;
    endtask

    // Check bytes of a sequence; seq holds the first byte in its top 8 bits.
    // nchk < len leaves the instruction in progress.
    task automatic collectBytes(input string tag, input logic [79:0] seq,
                                input int len, input int nchk, input bit toggle);
        logic [79:0] s;
        logic [7:0]  b;
        for (int i = 0; i < nchk; i++) begin
            s = seq << (8 * i);
            b = s[79:72];
            if (toggle) begin
                out_ready = 1'b0;
                checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
                checkOutput({tag, "_byte"}, 64'(out_byte), 64'(b));
                stepCycle();
                checkOutput({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
                checkOutput({tag, "_hold_byte"}, 64'(out_byte), 64'(b));
                checkOutput({tag, "_hold_last"}, 64'(out_last), 64'(i == len - 1));
                out_ready = 1'b1;
            end
            checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
            checkOutput({tag, "_byte"}, 64'(out_byte), 64'(b));
            checkOutput({tag, "_last"}, 64'(out_last), 64'(i == len - 1));
            checkOutput({tag, "_no_ready"}, 64'(in_ready), 64'd0);
            stepCycle();
        end
        if (nchk == len) begin
            checkOutput({tag, "_done_valid"}, 64'(out_valid), 64'd0);
            checkOutput({tag, "_done_byte"}, 64'(out_byte), 64'd0);
            checkOutput({tag, "_done_last"}, 64'(out_last), 64'd0);
            checkOutput({tag, "_done_ready"}, 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        icode     = 4'h0;
        ifun      = 4'h0;
        rA        = 4'h0;
        rB        = 4'h0;
        valC      = 64'd0;
        out_ready = 1'b1;
`ifdef ENC_PC_EN
        pc_load   = 1'b0;
        pc_init   = 64'd0;
`endif
        stepCycle();
        stepCycle();
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_byte", 64'(out_byte), 64'd0);
        checkOutput("rst_out_last", 64'(out_last), 64'd0);
        checkOutput("rst_instr_err", 64'(instr_err), 64'd0);
`ifdef ENC_PC_EN
        checkOutput("rst_out_pc", out_pc, 64'd0);
`endif
        reset = 1'b0;
        stepCycle();
        checkOutput("idle_in_ready", 64'(in_ready), 64'd1);

        // irmovq: ten consecutive bytes with out_ready held high
        applyStimulus(4'h3, 4'h0, 4'hF, 4'h2, 64'h0123456789ABCDEF);
        collectBytes("irmovq", 80'h30F2EFCDAB8967452301, 10, 10, 1'b0);

        // call: header plus constant, no register byte
        applyStimulus(4'h8, 4'h0, 4'hF, 4'hF, 64'h100);
        collectBytes("call", 80'h80000100000000000000, 9, 9, 1'b0);

        // addq with out_ready toggling: each byte held while stalled
        out_ready = 1'b0;
        applyStimulus(4'h6, 4'h0, 4'h1, 4'h2, 64'd0);
        collectBytes("addq", 80'h60120000000000000000, 2, 2, 1'b1);

        // Invalid icode: one-cycle error pulse, no bytes
        in_valid = 1'b1;
        icode    = 4'hD;
        ifun     = 4'h0;
        stepCycle();
        in_valid = 1'b0;
        checkOutput("bad_err_pulse", 64'(instr_err), 64'd1);
        checkOutput("bad_out_valid", 64'(out_valid), 64'd0);
        checkOutput("bad_in_ready", 64'(in_ready), 64'd1);
        stepCycle();
        checkOutput("bad_err_clear", 64'(instr_err), 64'd0);
        checkOutput("bad_out_valid2", 64'(out_valid), 64'd0);

        // rmmovq aborted by reset after the fourth byte, then a nop
        applyStimulus(4'h4, 4'h0, 4'h3, 4'h5, 64'h0807060504030201);
        collectBytes("rmmovq", 80'h40350102030405060708, 10, 4, 1'b0);
        reset = 1'b1;
        stepCycle();
        checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_out_byte", 64'(out_byte), 64'd0);
        reset = 1'b0;
        stepCycle();
        checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
        checkOutput("abort_still_idle", 64'(out_valid), 64'd0);
        applyStimulus(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
        collectBytes("nop", 80'h10000000000000000000, 1, 1, 1'b0);

        // halt (icode 0) with a non-zero ifun: single byte
        applyStimulus(4'h0, 4'h5, 4'h7, 4'h7, 64'hFFFF);
        collectBytes("halt", 80'h05000000000000000000, 1, 1, 1'b0);

`ifdef ENC_PC_EN
        // pc_load beats a simultaneous instruction, then wraps across rrmovq
        pc_load  = 1'b1;
        pc_init  = 64'hFFFFFFFFFFFFFFFF;
        in_valid = 1'b1;
        icode    = 4'h2;
        ifun     = 4'h0;
        rA       = 4'h3;
        rB       = 4'h4;
        stepCycle();
        pc_load  = 1'b0;
        in_valid = 1'b0;
        checkOutput("pc_load_value", out_pc, 64'hFFFFFFFFFFFFFFFF);
        checkOutput("pc_load_no_accept", 64'(out_valid), 64'd0);
        checkOutput("pc_load_in_ready", 64'(in_ready), 64'd1);
        applyStimulus(4'h2, 4'h0, 4'h3, 4'h4, 64'd0);
        checkOutput("pc_hdr_byte", 64'(out_byte), 64'h20);
        checkOutput("pc_hdr_addr", out_pc, 64'hFFFFFFFFFFFFFFFF);
        stepCycle();
        checkOutput("pc_reg_byte", 64'(out_byte), 64'h34);
        checkOutput("pc_reg_last", 64'(out_last), 64'd1);
        checkOutput("pc_reg_addr", out_pc, 64'd0);
        stepCycle();
        checkOutput("pc_after_addr", out_pc, 64'd1);
        checkOutput("pc_after_valid", 64'(out_valid), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
